dcache_dm: RTL and testbench
============================

// Module: dcache_dm
// PURPOSE
//  Data cache answering the CPU memory stage's load/store requests (addr/wdata/rdata/enables/miss).
//  Direct-mapped, write-back, write-allocate, LINE_WORDS words per line; sits between the memory stage and the DRAM controller.
//  Hits complete combinationally in the request cycle. On a miss, miss stays high while the FSM writes back a dirty victim and refills the line.
// PARAMETERS
//  INDEX_BITS   8  number of lines = 2**INDEX_BITS
//  OFFSET_BITS  2  words per line = 2**OFFSET_BITS (LINE_WORDS)
// PORTS
//  clk        in   1   clock
//  rstn       in   1   reset, synchronous, active-low
//  addr       in   32  CPU byte address; bits[1:0] ignored (word access only)
//  wdata      in   32  CPU store data
//  rdata      out  32  load data; valid only in a cycle with read_enable=1 and miss=0
//  write_enable in 1   store request; held by CPU until miss=0
//  read_enable  in 1   load request; held by CPU until miss=0
//  miss       out  1   1 = request not completed this cycle, CPU must stall and hold inputs
//  mem_req    out  1   DRAM word transaction request, held until mem_ack
//  mem_we     out  1   1 = write (writeback), 0 = read (fill)
//  mem_addr   out  32  word-aligned DRAM byte address
//  mem_wdata  out  32  writeback data
//  mem_rdata  in   32  fill data, valid in the mem_ack cycle
//  mem_ack    in   1   one-cycle completion pulse for the current transaction
// BEHAVIOUR
//  Address split: off=addr[2+:OFFSET_BITS], idx=addr[2+OFFSET_BITS+:INDEX_BITS], tag=remaining upper bits.
//  Arrays: tag, valid, dirty per line; data per word. Asynchronous read, written at posedge.
//  hit = state==IDLE && valid[idx] && tag[idx]==tag.
//  miss = (read_enable|write_enable) && !hit. Purely combinational, so it is high in every non-IDLE state.
//  rdata = data[idx][off] at all times. It is a don't-care unless read_enable=1 and miss=0.
//  Write hit: data[idx][off]<=wdata and dirty[idx]<=1 at the edge ending the hit cycle.
//  Both enables high: treated as a store; rdata shows the pre-store word.
//  FSM states: IDLE, WB, FILL. A word counter cnt (OFFSET_BITS wide) is cleared on every transition.
//   IDLE: a request that misses latches victim idx/tag and the request line address.
//         Next state is WB if valid&&dirty, else FILL.
//   WB: mem_req=1, mem_we=1, mem_addr={victim tag,idx,cnt,2'b00}, mem_wdata=data[idx][cnt].
//       On mem_ack: cnt++. The ack on cnt==LINE_WORDS-1 moves to FILL.
//   FILL: mem_req=1, mem_we=0, mem_addr={req tag,idx,cnt,2'b00}.
//         On mem_ack: data[idx][cnt]<=mem_rdata and cnt++.
//         The last ack writes tag, sets valid=1 and dirty=0, and moves to IDLE.
//   Return to IDLE: the held request hits in the following cycle (miss=0). A store completes then as a normal write hit.
//  Handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1 and not yet acked.
//   mem_req may stay high into the next word with the new address the cycle after an ack (back-to-back).
//   mem_ack with mem_req=0 is ignored.
//  Latency: a clean miss takes LINE_WORDS acks plus 1 cycle. A dirty miss takes 2*LINE_WORDS acks plus 1 cycle.
//  The CPU changing addr/enables mid-miss is illegal. The FSM completes on latched values.
//  Reset: state=IDLE, cnt=0, all valid=0 and dirty=0, mem_req=0, mem_we=0. Data/tag arrays are not cleared.
//   A reset mid-WB/FILL abandons the transaction immediately; the partial line stays invalid.
//   miss follows the combinational rule, so it is 1 after reset if any enable is high.
//  Counter wrap: cnt wraps to 0 naturally after the last word; no wrap-specific logic.
// TESTING
//  Cold load 0x0000_1004, DRAM word k = 0x1000+4k, ack 1 cycle after req:
//   4 fill reqs at 0x1000..0x100C with mem_we=0, then miss=0 and rdata=0x1004.
//  Load 0x1008 right after: miss=0 in the same cycle, rdata=0x1008, mem_req stays 0.
//  Store 0xDEAD_BEEF to 0x1000 (hit): miss=0, no mem traffic; a subsequent load 0x1000 returns 0xDEADBEEF.
//  Load 0x0000_5000 (same idx, other tag) after the store:
//   4 WB writes at 0x1000.. with mem_wdata word0=0xDEADBEEF, then 4 fills at 0x5000.., then miss=0.
//  Clean conflict miss: no mem_we=1 transaction is issued; fill only.
//  mem_ack delayed 0..7 random cycles: addr/we/wdata stay stable while req=1, and the result matches a reference model.
//  rstn=0 during the 2nd fill ack: mem_req=0 next cycle; a load to the same line re-misses and performs a full refill.

Source files
------------

// File: rtl/dcache_if.sv
// CPU memory-stage and DRAM-side signals of the direct-mapped data cache.
// The cache holds mem_addr/mem_we/mem_wdata stable while mem_req=1 until the one-cycle mem_ack;
// the CPU holds addr/wdata/enables stable while miss=1.
interface dcache_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        write_enable;
  logic        read_enable;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  addr, wdata, write_enable, read_enable, mem_rdata, mem_ack,
    output rdata, miss, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, wdata, write_enable, read_enable, mem_rdata, mem_ack,
    input  rdata, miss, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with combinational hits
// and a WB/FILL miss engine talking word transactions to DRAM.
module dcache_dm #(
  parameter int INDEX_BITS  = 8,
  parameter int OFFSET_BITS = 2
) (
  input  logic       clk,
  input  logic       rstn,
  dcache_if.slave    bus,
  output logic [1:0] state_dbg
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;
  localparam logic [OFFSET_BITS-1:0] FIRST_WORD = '0;

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2} state_t;

  logic [31:0]         data_mem [LINES*WORDS];
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;

  state_t                 state;
  logic [OFFSET_BITS-1:0] cnt;
  logic [INDEX_BITS-1:0]  v_idx;
  logic [TAG_BITS-1:0]    v_tag;
  logic [TAG_BITS-1:0]    r_tag;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [31:0]            mem_addr_q;

  logic [OFFSET_BITS-1:0] off;
  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [1:0]             unused_addr_lo;
  logic                   hit;
  logic                   write_hit;
  logic                   fill_ack;
  logic                   fill_last;

  assign off            = bus.addr[2 +: OFFSET_BITS];
  assign idx            = bus.addr[2+OFFSET_BITS +: INDEX_BITS];
  assign req_tag        = bus.addr[31 -: TAG_BITS];
  assign unused_addr_lo = bus.addr[1:0];

  assign hit       = (state == IDLE) && valid_q[idx] && (tag_mem[idx] == req_tag);
  assign write_hit = hit && bus.write_enable;
  assign fill_ack  = (state == FILL) && bus.mem_ack;
  assign fill_last = fill_ack && (cnt == LAST_WORD);

  assign bus.miss      = (bus.read_enable || bus.write_enable) && !hit;
  assign bus.rdata     = data_mem[{idx, off}];
  assign bus.mem_wdata = data_mem[{v_idx, cnt}];
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign state_dbg     = state;

  // Storage arrays carry no reset; a line is only trusted once valid_q is set.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (write_hit) begin
        data_mem[{idx, off}] <= bus.wdata;
      end else if (fill_ack) begin
        data_mem[{v_idx, cnt}] <= bus.mem_rdata;
      end
      if (fill_last) begin
        tag_mem[v_idx] <= r_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      v_idx      <= '0;
      v_tag      <= '0;
      r_tag      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hit) begin
            dirty_q[idx] <= 1'b1;
          end
          if (bus.miss) begin
            v_idx     <= idx;
            v_tag     <= tag_mem[idx];
            r_tag     <= req_tag;
            cnt       <= '0;
            mem_req_q <= 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state      <= WB;
              mem_we_q   <= 1'b1;
              mem_addr_q <= {tag_mem[idx], idx, FIRST_WORD, 2'b00};
            end else begin
              state      <= FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag, idx, FIRST_WORD, 2'b00};
            end
          end
        end
        WB: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_WORD) begin
              state      <= FILL;
              cnt        <= '0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {r_tag, v_idx, FIRST_WORD, 2'b00};
            end else begin
              mem_addr_q <= {v_tag, v_idx, cnt + 1'b1, 2'b00};
            end
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 1'b1;
            // Last word: line becomes valid and clean; the held request hits next cycle.
            if (cnt == LAST_WORD) begin
              state          <= IDLE;
              cnt            <= '0;
              mem_req_q      <= 1'b0;
              valid_q[v_idx] <= 1'b1;
              dirty_q[v_idx] <= 1'b0;
            end else begin
              mem_addr_q <= {r_tag, v_idx, cnt + 1'b1, 2'b00};
            end
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: DRAM responder, table of directed accesses, reset-mid-fill sequence,
// and random accesses with random ack delay checked against an architectural memory model.
module tb_dcache_dm;
  localparam int BUDGET = 300;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_cyc;
    int          exp_nwr;
    logic [31:0] wb_base;
    int          exp_nrd;
  } vec_t;

  logic       clk;
  logic       rstn;
  logic [1:0] state_dbg;

  dcache_if bus();

  dcache_dm dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  txn_t        txn_q[$];
  logic [31:0] dram     [logic [31:0]];
  logic [31:0] arch_mem [logic [31:0]];

  bit          ack_rand   = 1'b0;
  int          delay_left = -1;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [31:0] dram_rd(input logic [31:0] a);
    return dram.exists(a) ? dram[a] : a;
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // DRAM responder: acks each word after a fixed or random delay, checks stability and WB data
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) begin
        delay_left = -1;
      end else begin
        if (delay_left < 0) begin
          delay_left = ack_rand ? int'($urandom_range(7, 0)) : 1;
          cap_we     = bus.mem_we;
          cap_addr   = bus.mem_addr;
          cap_wdata  = bus.mem_wdata;
        end else begin
          check("stable_addr", bus.mem_addr, cap_addr);
          check("stable_we", {31'd0, bus.mem_we}, {31'd0, cap_we});
          if (cap_we) check("stable_wdata", bus.mem_wdata, cap_wdata);
        end
        if (delay_left == 0) begin
          if (bus.mem_we) begin
            check("wb_data", bus.mem_wdata, arch_rd(bus.mem_addr));
            dram[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = dram_rd(bus.mem_addr);
          end
          txn_q.push_back('{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata});
          bus.mem_ack = 1'b1;
          delay_left  = -1;
        end else begin
          delay_left--;
        end
      end
    end
  end

  // driver: one CPU access, held until miss drops; cyc = number of stalled cycles
  task automatic access(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, output int cyc);
    bit          done;
    logic [31:0] want;
    @(negedge clk);
    bus.addr         = a;
    bus.wdata        = wd;
    bus.write_enable = we;
    bus.read_enable  = re;
    if (re) exp_q.push_back(exp_rd);
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      #1;
      if (!bus.miss) begin
        done = 1'b1;
      end else if (cyc >= BUDGET) begin
        check("miss_timeout", {31'd0, bus.miss}, 32'd0);
        done = 1'b1;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (re) begin
      want = exp_q.pop_front();
      if (!bus.miss) check("rdata", bus.rdata, want);
    end
    @(posedge clk);
    if (we && !bus.miss) arch_mem[{a[31:2], 2'b00}] = wd;
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   n;
    txn_t t;
    txn_q.delete();
    access(v.we, v.re, v.addr, v.wdata, v.exp_rd, cyc);
    check("miss_cycles", cyc, v.exp_cyc);
    check("txn_count", txn_q.size(), v.exp_nwr + v.exp_nrd);
    n = (txn_q.size() < v.exp_nwr + v.exp_nrd) ? txn_q.size() : v.exp_nwr + v.exp_nrd;
    for (int k = 0; k < n; k++) begin
      t = txn_q[k];
      if (k < v.exp_nwr) begin
        check("txn_we", {31'd0, t.we}, 32'd1);
        check("txn_addr", t.addr, v.wb_base + 32'(4 * k));
      end else begin
        check("txn_we", {31'd0, t.we}, 32'd0);
        check("txn_addr", t.addr, (v.addr & 32'hFFFF_FFF0) + 32'(4 * (k - v.exp_nwr)));
      end
    end
  endtask

  vec_t vecs[12];

  initial begin
    vec_t        rv;
    int          nack;
    int          guard;
    int          cyc;
    int          op;
    logic [31:0] a;
    logic [31:0] wd;

    // clean miss: 1 + 4*(1+1) cycles, dirty miss: 1 + 8*(1+1) cycles with ack one cycle after req
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_1004, 32'h0,         32'h0000_1004, 9,  0, 32'h0,    4};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_1008, 32'h0,         32'h0000_1008, 0,  0, 32'h0,    0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         0,  0, 32'h0,    0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 0,  0, 32'h0,    0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_5000, 32'h0,         32'h0000_5000, 17, 4, 32'h1000, 4};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 9,  0, 32'h0,    4};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_1004, 32'h1234_5678, 32'h0000_1004, 0,  0, 32'h0,    0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_1004, 32'h0,         32'h1234_5678, 0,  0, 32'h0,    0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_3014, 32'hCAFE_0001, 32'h0,         9,  0, 32'h0,    4};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_3017, 32'h0,         32'hCAFE_0001, 0,  0, 32'h0,    0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_2010, 32'h0,         32'h0000_2010, 17, 4, 32'h3010, 4};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_301C, 32'h0,         32'h0000_301C, 9,  0, 32'h0,    4};

    bus.addr         = 32'h0000_1004;
    bus.wdata        = '0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b1;
    rstn             = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    check("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("reset_miss_with_enable", {31'd0, bus.miss}, 32'd1);
    bus.read_enable = 1'b0;
    #1;
    check("reset_miss_idle", {31'd0, bus.miss}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end
    check("vec_mem_req_idle", {31'd0, bus.mem_req}, 32'd0);

    // reset during the second fill ack abandons the refill
    txn_q.delete();
    @(negedge clk);
    bus.addr        = 32'h0000_8040;
    bus.read_enable = 1'b1;
    nack  = 0;
    guard = 0;
    while (nack < 2 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
      if (bus.mem_ack && !bus.mem_we) nack++;
    end
    check("rst_fill_acks", nack, 2);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_fill_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mid_fill_state", {30'd0, state_dbg}, 32'd0);
    check("rst_mid_fill_miss", {31'd0, bus.miss}, 32'd1);
    bus.read_enable = 1'b0;
    rstn = 1'b1;
    arch_mem = dram;
    rv = '{1'b0, 1'b1, 32'h0000_8044, 32'h0, 32'h0000_8044, 9, 0, 32'h0, 4};
    run_vec(rv);

    // random accesses, random ack delay 0..7
    ack_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(2, 0));
      a  = 32'h0010_0000 | ({30'd0, 2'($urandom_range(3, 0))} << 12)
                         | ({30'd0, 2'($urandom_range(3, 0))} << 4)
                         | ({30'd0, 2'($urandom_range(3, 0))} << 2);
      wd = $urandom;
      access(op != 0, op != 1, a, wd, arch_rd(a), cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
